sd_cmd_phy: RTL and testbench

Physical-layer endpoint for the SD command path, facing the host command controller. It accepts a 40-bit command frame on a strobe handshake, appends CRC7 and the end bit, and shifts the 48-bit frame onto the CMD line. It then waits for the card's start bit and deserialises a 48- or 136-bit response, or times out. Finally it hands the response back to the controller with a strobe/ack handshake.

---
 rtl/sd_cmd_phy_if.sv | 46 ++++
 rtl/sd_cmd_phy.sv | 248 ++++++++++++++++++++++++
 tb/tb_sd_cmd_phy.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_phy_if.sv
// Controller- and line-side signals of the SD command PHY, bundled for port connection.
// master = host controller plus card model, slave = the PHY.
interface sd_cmd_phy_if;
    logic         strobe_in;
    logic         ack_in;
    logic         idle_in;
    logic [39:0]  cmd_in;
    logic         strobe_out;
    logic         ack_out;
    logic [135:0] cmd_out;
    logic         resp_timeout;
    logic         crc_error;
    logic         cmd_pin_out;
    logic         cmd_pin_oe;
    logic         cmd_pin_in;

    modport master (
        output strobe_in,
        output ack_in,
        output idle_in,
        output cmd_in,
        output cmd_pin_in,
        input  strobe_out,
        input  ack_out,
        input  cmd_out,
        input  resp_timeout,
        input  crc_error,
        input  cmd_pin_out,
        input  cmd_pin_oe
    );

    modport slave (
        input  strobe_in,
        input  ack_in,
        input  idle_in,
        input  cmd_in,
        input  cmd_pin_in,
        output strobe_out,
        output ack_out,
        output cmd_out,
        output resp_timeout,
        output crc_error,
        output cmd_pin_out,
        output cmd_pin_oe
    );
endinterface

// File: rtl/sd_cmd_phy.sv
// SD CMD-line PHY: sends a 48-bit command frame with CRC7 and captures a 48/136-bit response.
// Optional response CRC7 checker is enabled by defining SD_CMD_PHY_RESP_CRC_EN.
module sd_cmd_phy #(
    parameter int NCR_MAX = 64
) (
    input  logic        clock,
    input  logic        reset,
    sd_cmd_phy_if.slave phy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_RESP,
        S_RECV,
        S_DELIVER,
        S_DONE,
        S_RELEASE
    } state_t;

    localparam logic [7:0] NCR_LIMIT  = 8'(NCR_MAX);
    localparam logic [7:0] FRAME_BITS = 8'd48;
    localparam logic [7:0] CRC_START  = 8'd40;
    localparam logic [7:0] END_BIT    = 8'd47;

    // CRC7, generator x^7 + x^3 + 1, one bit per call, MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t       state_q, state_d;
    logic [47:0]  sr_q, sr_d;
    logic [6:0]   crc_q, crc_d;
    logic [5:0]   idx_q, idx_d;
    logic [7:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   wait_cnt_q, wait_cnt_d;
    logic [135:0] cmd_out_q, cmd_out_d;
    logic         strobe_out_q, strobe_out_d;
    logic         ack_out_q, ack_out_d;
    logic         timeout_q, timeout_d;
    logic         pin_out_q, pin_out_d;
    logic         pin_oe_q, pin_oe_d;

    logic         latch_cmd;
    logic         resp_none;
    logic         resp_long;
    logic [7:0]   resp_bits;
    logic         recv_done;

    assign latch_cmd = (state_q == S_IDLE) && phy.strobe_in && !phy.idle_in;
    assign resp_none = idx_q inside {6'd0, 6'd4, 6'd15};
    assign resp_long = idx_q inside {6'd2, 6'd9, 6'd10};
    assign resp_bits = resp_long ? 8'd136 : 8'd48;
    assign recv_done = (state_q == S_RECV) && (bit_cnt_q >= resp_bits);

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        crc_d        = crc_q;
        idx_d        = idx_q;
        bit_cnt_d    = bit_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        cmd_out_d    = cmd_out_q;
        strobe_out_d = strobe_out_q;
        ack_out_d    = 1'b0;
        timeout_d    = timeout_q;
        pin_out_d    = pin_out_q;
        pin_oe_d     = pin_oe_q;

        unique case (state_q)
            S_IDLE: begin
                if (latch_cmd) begin
                    sr_d         = {phy.cmd_in, 7'b0, 1'b1};
                    idx_d        = phy.cmd_in[37:32];
                    crc_d        = '0;
                    bit_cnt_d    = '0;
                    wait_cnt_d   = '0;
                    cmd_out_d    = '0;
                    strobe_out_d = 1'b0;
                    timeout_d    = 1'b0;
                    state_d      = S_SEND;
                end
            end

            S_SEND: begin
                if (bit_cnt_q < FRAME_BITS) begin
                    pin_oe_d  = 1'b1;
                    sr_d      = {sr_q[46:0], 1'b0};
                    bit_cnt_d = sat_inc(bit_cnt_q);
                    if (bit_cnt_q < CRC_START) begin
                        pin_out_d = sr_q[47];
                        crc_d     = crc7_step(crc_q, sr_q[47]);
                    end else if (bit_cnt_q < END_BIT) begin
                        // CRC field is shifted out of the CRC register itself.
                        pin_out_d = crc_q[6];
                        crc_d     = {crc_q[5:0], 1'b0};
                    end else begin
                        pin_out_d = 1'b1;
                    end
                end else begin
                    pin_oe_d  = 1'b0;
                    pin_out_d = 1'b1;
                    bit_cnt_d = '0;
                    if (resp_none) begin
                        strobe_out_d = 1'b1;
                        state_d      = S_DELIVER;
                    end else begin
                        wait_cnt_d = 8'd1;
                        state_d    = S_WAIT_RESP;
                    end
                end
            end

            S_WAIT_RESP: begin
                // A start bit on the final wait cycle still wins over the timeout.
                if (!phy.cmd_pin_in) begin
                    cmd_out_d = {cmd_out_q[134:0], 1'b0};
                    bit_cnt_d = 8'd1;
                    state_d   = S_RECV;
                end else if (wait_cnt_q >= NCR_LIMIT) begin
                    timeout_d    = 1'b1;
                    cmd_out_d    = '0;
                    strobe_out_d = 1'b1;
                    state_d      = S_DELIVER;
                end else begin
                    wait_cnt_d = sat_inc(wait_cnt_q);
                end
            end

            S_RECV: begin
                if (recv_done) begin
                    strobe_out_d = 1'b1;
                    state_d      = S_DELIVER;
                end else begin
                    cmd_out_d = {cmd_out_q[134:0], phy.cmd_pin_in};
                    bit_cnt_d = sat_inc(bit_cnt_q);
                end
            end

            S_DELIVER: begin
                if (phy.ack_in) begin
                    strobe_out_d = 1'b0;
                    state_d      = S_DONE;
                end
            end

            S_DONE: begin
                ack_out_d = 1'b1;
                state_d   = S_RELEASE;
            end

            S_RELEASE: begin
                // Hold off until the controller drops its strobe so it cannot retrigger.
                if (!phy.strobe_in) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sr_q         <= '0;
            crc_q        <= '0;
            idx_q        <= '0;
            bit_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            cmd_out_q    <= '0;
            strobe_out_q <= 1'b0;
            ack_out_q    <= 1'b0;
            timeout_q    <= 1'b0;
            pin_out_q    <= 1'b1;
            pin_oe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            crc_q        <= crc_d;
            idx_q        <= idx_d;
            bit_cnt_q    <= bit_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            cmd_out_q    <= cmd_out_d;
            strobe_out_q <= strobe_out_d;
            ack_out_q    <= ack_out_d;
            timeout_q    <= timeout_d;
            pin_out_q    <= pin_out_d;
            pin_oe_q     <= pin_oe_d;
        end
    end

    assign phy.strobe_out   = strobe_out_q;
    assign phy.ack_out      = ack_out_q;
    assign phy.cmd_out      = cmd_out_q;
    assign phy.resp_timeout = timeout_q;
    assign phy.cmd_pin_out  = pin_out_q;
    assign phy.cmd_pin_oe   = pin_oe_q;

`ifdef SD_CMD_PHY_RESP_CRC_EN
    logic [6:0] rx_crc_q, rx_crc_d;
    logic       crc_err_q, crc_err_d;
    logic [7:0] rx_pos;
    logic [7:0] rx_top;
    logic       rx_take;

    // Frame position of the bit being sampled this cycle (start bit = highest position).
    assign rx_pos  = resp_bits - 8'd1 - bit_cnt_q;
    assign rx_top  = resp_long ? 8'd127 : 8'd47;
    assign rx_take = ((state_q == S_WAIT_RESP) && !phy.cmd_pin_in) ||
                     ((state_q == S_RECV) && !recv_done);

    always_comb begin
        rx_crc_d  = rx_crc_q;
        crc_err_d = crc_err_q;
        if (latch_cmd) begin
            rx_crc_d  = '0;
            crc_err_d = 1'b0;
        end else if (rx_take && (rx_pos >= 8'd8) && (rx_pos <= rx_top)) begin
            rx_crc_d = crc7_step(rx_crc_q, phy.cmd_pin_in);
        end else if (recv_done) begin
            // ACMD41 (R3) carries an all-ones CRC field and is never flagged.
            crc_err_d = (rx_crc_q != cmd_out_q[7:1]) && (idx_q != 6'd41);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_crc_q  <= '0;
            crc_err_q <= 1'b0;
        end else begin
            rx_crc_q  <= rx_crc_d;
            crc_err_q <= crc_err_d;
        end
    end

    assign phy.crc_error = crc_err_q;
`else
    assign phy.crc_error = 1'b0;
`endif
endmodule

// File: tb/tb_sd_cmd_phy.sv
// Bench for sd_cmd_phy: scripts stimulus and expected outputs per clock cycle from the
// protocol rules, then replays the stimulus and checks every cycle.
module tb_sd_cmd_phy;
    localparam int NCR_MAX = 64;
    localparam int MAXC    = 16384;
`ifdef SD_CMD_PHY_RESP_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    sd_cmd_phy_if bus ();

    sd_cmd_phy #(.NCR_MAX(NCR_MAX)) dut (
        .clock (clock),
        .reset (reset),
        .phy   (bus)
    );

    always #5 clock = ~clock;

    // in_*[c]: driven just after edge c, sampled at edge c+1. exp_*[c]: outputs after edge c.
    logic         in_strobe [MAXC];
    logic         in_ack    [MAXC];
    logic         in_idle   [MAXC];
    logic         in_pin    [MAXC];
    logic         in_reset  [MAXC];
    logic [39:0]  in_cmd    [MAXC];
    logic         exp_oe    [MAXC];
    logic         exp_pin   [MAXC];
    logic         exp_strb  [MAXC];
    logic         exp_ack   [MAXC];
    logic         exp_deliv [MAXC];
    logic         exp_to    [MAXC];
    logic         exp_crc   [MAXC];
    logic [135:0] exp_cmd   [MAXC];
    logic         chk_cmd0  [MAXC];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int t_next      = 0;
    int t_end       = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Remainder of data(x) * x^7 divided by x^7 + x^3 + 1, by long division.
    function automatic logic [6:0] crc7_of(input logic [135:0] data, input int nbits);
        logic [142:0] v;
        v = {data, 7'b0};
        for (int i = nbits + 6; i >= 7; i--) begin
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        end
        return v[6:0];
    endfunction

    function automatic int resp_len(input logic [5:0] idx);
        if (idx inside {6'd0, 6'd4, 6'd15}) return 0;
        if (idx inside {6'd2, 6'd9, 6'd10}) return 136;
        return 48;
    endfunction

    function automatic logic [135:0] make_resp(input logic [5:0] idx, input int len,
                                               input logic [119:0] payload, input int flip);
        logic [135:0] r;
        r = '0;
        if (len == 136) begin
            r[135:128] = 8'h3F;
            r[127:8]   = payload;
            r[7:1]     = crc7_of(136'(payload), 120);
        end else begin
            r[45:40] = (idx == 6'd41) ? 6'h3F : idx;
            r[39:8]  = payload[31:0];
            r[7:1]   = (idx == 6'd41) ? 7'h7F : crc7_of(136'(r[47:8]), 40);
        end
        r[0] = 1'b1;
        if (flip > 0) r[flip] = ~r[flip];
        return r;
    endfunction

    function automatic logic exp_crc_err(input logic [5:0] idx, input int len, input logic [135:0] r);
        logic mism;
        if (len == 136) mism = crc7_of(136'(r[127:8]), 120) != r[7:1];
        else            mism = crc7_of(136'(r[47:8]), 40) != r[7:1];
        return CRC_EN && (idx != 6'd41) && mism;
    endfunction

    // delay: start bit sampled delay cycles after WAIT_RESP entry (0 = card silent).
    task automatic txn(input logic [39:0] cmd, input int delay, input logic [135:0] resp,
                       input int hold, input int ack_dly);
        int t, n, s, d, a, len, ex;
        logic [47:0]  frame;
        logic [5:0]   idx;
        logic [135:0] r;
        logic         to, ce;
        t = t_next;
        n = t + 1;
        idx = cmd[37:32];
        len = resp_len(idx);
        frame = {cmd, crc7_of(136'(cmd), 40), 1'b1};
        for (int c = t; c < t + hold; c++) in_strobe[c] = 1'b1;
        in_cmd[t]  = cmd;
        in_idle[t] = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            exp_oe[n + k]  = 1'b1;
            exp_pin[n + k] = frame[48 - k];
        end
        r = '0; to = 1'b0; ce = 1'b0;
        if (len == 0) begin
            d = n + 49;
        end else if (delay == 0) begin
            d = n + 49 + NCR_MAX;
            to = 1'b1;
        end else begin
            s = n + 49 + delay;
            for (int j = 0; j < len; j++) in_pin[s - 1 + j] = resp[len - 1 - j];
            d = s + len;
            r = resp;
            ce = exp_crc_err(idx, len, resp);
        end
        a = d + ack_dly;
        in_ack[a - 1] = 1'b1;
        for (int c = d; c < a; c++) begin
            exp_strb[c]  = 1'b1;
            exp_deliv[c] = 1'b1;
            exp_cmd[c]   = r;
            exp_to[c]    = to;
            exp_crc[c]   = ce;
        end
        exp_ack[a + 1] = 1'b1;
        ex = (a + 2 > t + hold + 1) ? a + 2 : t + hold + 1;
        t_next = ex + int'($urandom_range(0, 3));
    endtask

    task automatic txn_reset(input logic [39:0] cmd, input int bitn);
        int n;
        logic [47:0] frame;
        n = t_next + 1;
        frame = {cmd, crc7_of(136'(cmd), 40), 1'b1};
        in_strobe[t_next] = 1'b1;
        in_cmd[t_next]    = cmd;
        in_idle[t_next]   = 1'b0;
        for (int k = 1; k < bitn; k++) begin
            exp_oe[n + k]  = 1'b1;
            exp_pin[n + k] = frame[48 - k];
        end
        in_reset[n + bitn - 1] = 1'b1;
        chk_cmd0[n + bitn]     = 1'b1;
        t_next = n + bitn + 1;
    endtask

    task automatic apply(input int c);
        reset          = in_reset[c];
        bus.strobe_in  = in_strobe[c];
        bus.ack_in     = in_ack[c];
        bus.idle_in    = in_idle[c];
        bus.cmd_in     = in_cmd[c];
        bus.cmd_pin_in = in_pin[c];
    endtask

    initial forever begin
        @(negedge clock);
        if (cyc >= 1 && cyc < t_end) begin
            check("cmd_pin_oe", 136'(bus.cmd_pin_oe), 136'(exp_oe[cyc]));
            check("cmd_pin_out", 136'(bus.cmd_pin_out), 136'(exp_pin[cyc]));
            check("strobe_out", 136'(bus.strobe_out), 136'(exp_strb[cyc]));
            check("ack_out", 136'(bus.ack_out), 136'(exp_ack[cyc]));
            if (exp_deliv[cyc]) begin
                check("cmd_out", bus.cmd_out, exp_cmd[cyc]);
                check("resp_timeout", 136'(bus.resp_timeout), 136'(exp_to[cyc]));
                check("crc_error", 136'(bus.crc_error), 136'(exp_crc[cyc]));
            end
            if (chk_cmd0[cyc]) check("cmd_out_reset", bus.cmd_out, 136'(0));
        end
    end

    initial begin
        logic [5:0]   idx_list [11];
        logic [127:0] rnd;
        logic [135:0] r1;
        logic [47:0]  f0;
        logic [5:0]   idx;
        int           len, flip, ntx;

        idx_list = '{6'd0, 6'd2, 6'd4, 6'd8, 6'd9, 6'd10, 6'd15, 6'd17, 6'd24, 6'd41, 6'd55};
        for (int c = 0; c < MAXC; c++) begin
            in_strobe[c] = 1'b0;  in_ack[c] = 1'b0;  in_pin[c] = 1'b1;  in_reset[c] = 1'b0;
            in_idle[c]   = 1'($urandom_range(0, 1));
            in_cmd[c]    = {8'($urandom), $urandom};
            exp_oe[c]    = 1'b0;  exp_pin[c] = 1'b1;  exp_strb[c] = 1'b0;  exp_ack[c] = 1'b0;
            exp_deliv[c] = 1'b0;  exp_to[c]  = 1'b0;  exp_crc[c]  = 1'b0;  exp_cmd[c] = '0;
            chk_cmd0[c]  = 1'b0;
        end

        // Known-answer values that pin the reference model.
        check("model_crc_cmd0", 136'(crc7_of(136'(40'h40_0000_0000), 40)), 136'(7'h4A));
        check("model_crc_cmd8", 136'(crc7_of(136'(40'h48_0000_01AA), 40)), 136'(7'h43));
        f0 = {40'h40_0000_0000, crc7_of(136'(40'h40_0000_0000), 40), 1'b1};
        check("model_cmd0_tail", 136'(f0[7:0]), 136'(8'h95));
        r1 = make_resp(6'd17, 48, 120'h900, 0);
        check("model_r1_index", 136'(r1[45:40]), 136'(6'd17));
        check("model_r1_status", 136'(r1[39:8]), 136'(32'h0000_0900));

        in_reset[0] = 1'b1;  in_reset[1] = 1'b1;
        chk_cmd0[1] = 1'b1;  chk_cmd0[2] = 1'b1;
        in_idle[0]  = 1'b0;  in_idle[1]  = 1'b0;
        t_next = 3;

        txn({2'b01, 6'd0, 32'h0}, 0, '0, 60, 3);
        txn({2'b01, 6'd17, 32'h0000_0200}, 9, r1, 1, 2);
        rnd = {$urandom, $urandom, $urandom, $urandom};
        txn({2'b01, 6'd2, 32'h0}, 5, make_resp(6'd2, 136, rnd[119:0], 0), 2, 1);
        txn({2'b01, 6'd8, 32'h0000_01AA}, 0, '0, 1, 4);
        txn({2'b01, 6'd17, $urandom}, NCR_MAX, make_resp(6'd17, 48, 120'($urandom), 0), 1, 1);
        txn({2'b01, 6'd17, $urandom}, 3, make_resp(6'd17, 48, 120'($urandom), 3), 1, 1);
        txn({2'b01, 6'd41, 32'h40FF_8000}, 2, make_resp(6'd41, 48, 120'h80FF_8000, 0), 1, 1);
        in_strobe[t_next] = 1'b1;
        in_idle[t_next]   = 1'b1;
        t_next = t_next + 3;
        txn_reset({2'b01, 6'd17, 32'hDEAD_BEEF}, 20);
        txn({2'b01, 6'd55, 32'h0}, 1, make_resp(6'd55, 48, 120'h120, 0), 1, 1);

        ntx = 0;
        while (ntx < 30 && t_next < MAXC - 400) begin
            idx  = idx_list[$urandom_range(0, 10)];
            len  = resp_len(idx);
            rnd  = {$urandom, $urandom, $urandom, $urandom};
            flip = 0;
            if (len > 0 && $urandom_range(0, 3) == 0) flip = int'($urandom_range(1, len - 2));
            txn({2'b01, idx, $urandom}, int'($urandom_range(0, NCR_MAX)),
                make_resp(idx, len, rnd[119:0], flip),
                int'($urandom_range(1, 70)), int'($urandom_range(1, 6)));
            ntx++;
        end
        t_end = t_next + 5;

        for (int c = 0; c < t_end; c++) begin
            apply(c);
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
